// File: rtl/quant_coeff_loader.sv
// -----------------------------------------------------------------------------
// quant_coeff_loader
//
// Watches the software quantiser address/data registers (already in the
// user_clk domain). When the commit toggle (addr bit 31) changes and the
// address register has been steady long enough, it writes one coefficient,
// or a run of identical coefficients, into the quantiser gain RAM through a
// single write port. It also builds a status word for software readback.
//
// Optional build macro:
//   QUANT_LOADER_READBACK_EN - after each write, re-read the word and flag a
//                              sticky mismatch if the RAM does not return it
//                              (3 cycles per word). Undefined: 1 cycle per
//                              word, coef_rd_data ignored, status bit 17 = 0.
//
// Ports:
//   user_clk      fabric clock, rising edge
//   user_rst      synchronous reset, active-high
//   addr_reg_in   [31] commit toggle, [25:16] fill length-1, [ADDR_W-1:0] base
//   data_reg_in   coefficient value
//   coef_addr     RAM address
//   coef_data     RAM write data
//   coef_we       RAM write enable, one word per asserted cycle
//   coef_rd_data  RAM read data, valid one cycle after coef_addr
//   busy          high while a fill (or its verify cycles) is in progress
//   status_out    [15:0] words written, [16] busy, [17] mismatch sticky,
//                 [18] overrun sticky, [31:19] zero
// -----------------------------------------------------------------------------
module quant_coeff_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int SETTLE = 2
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       addr_reg_in,
    input  logic [DATA_W-1:0] data_reg_in,
    output logic [ADDR_W-1:0] coef_addr,
    output logic [DATA_W-1:0] coef_data,
    output logic              coef_we,
    input  logic [DATA_W-1:0] coef_rd_data,
    output logic              busy,
    output logic [31:0]       status_out
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_WRITE = 3'd2,
        ST_VADDR = 3'd3,
        ST_VCMP  = 3'd4
    } state_t;

    logic [31:0]       r_addr;
    logic [DATA_W-1:0] r_data;
    logic [3:0]        settle_cnt_r;

    state_t            state_r,       state_n;
    logic              last_toggle_r, last_toggle_n;
    logic [ADDR_W-1:0] cur_addr_r,    cur_addr_n;
    logic [9:0]        remaining_r,   remaining_n;
    logic [DATA_W-1:0] coeff_r,       coeff_n;
    logic [15:0]       words_r,       words_n;
    logic              overrun_r,     overrun_n;
    logic              mismatch_r,    mismatch_n;

    logic              toggle_seen_s;
    logic              settled_s;
    logic              fill_s;
    logic              fill_next_s;

`ifndef QUANT_LOADER_READBACK_EN
    // Read data only matters for the verify path.
    logic              unused_rd_s;
    assign unused_rd_s = ^coef_rd_data;
`endif

    // Input capture: loads every cycle, reset included, so that INIT sees the
    // real toggle level that was present while reset was held.
    always_ff @(posedge user_clk) begin
        r_addr <= addr_reg_in;
        r_data <= data_reg_in;
    end

    // Settling counter. Comparing the incoming value with r_addr is the
    // "r_addr changed since last cycle" test evaluated as r_addr is loaded, so
    // the count is 0 in the first cycle r_addr holds a new value.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            settle_cnt_r <= 4'd0;
        end else if (addr_reg_in != r_addr) begin
            settle_cnt_r <= 4'd0;
        end else if (settle_cnt_r != SETTLE_C) begin
            settle_cnt_r <= settle_cnt_r + 4'd1;
        end else begin
            settle_cnt_r <= settle_cnt_r;
        end
    end

    assign toggle_seen_s = (r_addr[31] != last_toggle_r);
    assign settled_s     = (settle_cnt_r == SETTLE_C);
    assign fill_s        = (state_r == ST_WRITE) || (state_r == ST_VADDR) ||
                           (state_r == ST_VCMP);
    assign fill_next_s   = (state_n == ST_WRITE) || (state_n == ST_VADDR) ||
                           (state_n == ST_VCMP);

    // Next-state and datapath update.
    always_comb begin
        state_n       = state_r;
        last_toggle_n = last_toggle_r;
        cur_addr_n    = cur_addr_r;
        remaining_n   = remaining_r;
        coeff_n       = coeff_r;
        words_n       = words_r;
        mismatch_n    = mismatch_r;

        case (state_r)
            ST_INIT: begin
                // Adopt whatever toggle level survived reset so it never fires.
                last_toggle_n = r_addr[31];
                state_n       = ST_IDLE;
            end
            ST_IDLE: begin
                if (toggle_seen_s && settled_s) begin
                    cur_addr_n    = r_addr[ADDR_W-1:0];
                    remaining_n   = r_addr[25:16];
                    coeff_n       = r_data;
                    last_toggle_n = r_addr[31];
                    state_n       = ST_WRITE;
                end else begin
                    state_n       = ST_IDLE;
                end
            end
            ST_WRITE: begin
                words_n = words_r + 16'd1;
`ifdef QUANT_LOADER_READBACK_EN
                state_n = ST_VADDR;
`else
                if (remaining_r == 10'd0) begin
                    // Resync so a toggle seen during the fill is not replayed.
                    last_toggle_n = r_addr[31];
                    state_n       = ST_IDLE;
                end else begin
                    remaining_n   = remaining_r - 10'd1;
                    cur_addr_n    = cur_addr_r + ADDR_W'(1);
                    state_n       = ST_WRITE;
                end
`endif
            end
`ifdef QUANT_LOADER_READBACK_EN
            ST_VADDR: begin
                // Address held one cycle so the RAM can return the word.
                state_n = ST_VCMP;
            end
            ST_VCMP: begin
                if (coef_rd_data != coeff_r) begin
                    mismatch_n = 1'b1;
                end else begin
                    mismatch_n = mismatch_r;
                end
                if (remaining_r == 10'd0) begin
                    last_toggle_n = r_addr[31];
                    state_n       = ST_IDLE;
                end else begin
                    remaining_n   = remaining_r - 10'd1;
                    cur_addr_n    = cur_addr_r + ADDR_W'(1);
                    state_n       = ST_WRITE;
                end
            end
`endif
            default: begin
                state_n = ST_INIT;
            end
        endcase

        // A commit arriving mid-fill is dropped and remembered as an overrun.
        if (fill_s && toggle_seen_s) begin
            overrun_n = 1'b1;
        end else begin
            overrun_n = overrun_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_r       <= ST_INIT;
            last_toggle_r <= 1'b0;
            cur_addr_r    <= {ADDR_W{1'b0}};
            remaining_r   <= 10'd0;
            coeff_r       <= {DATA_W{1'b0}};
            words_r       <= 16'd0;
            overrun_r     <= 1'b0;
            mismatch_r    <= 1'b0;
        end else begin
            state_r       <= state_n;
            last_toggle_r <= last_toggle_n;
            cur_addr_r    <= cur_addr_n;
            remaining_r   <= remaining_n;
            coeff_r       <= coeff_n;
            words_r       <= words_n;
            overrun_r     <= overrun_n;
            mismatch_r    <= mismatch_n;
        end
    end

    // Registered outputs, built from next-state values so coef_we lines up
    // exactly with the cycles spent in WRITE.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            coef_we    <= 1'b0;
            coef_addr  <= {ADDR_W{1'b0}};
            coef_data  <= {DATA_W{1'b0}};
            busy       <= 1'b0;
            status_out <= 32'd0;
        end else begin
            coef_we    <= (state_n == ST_WRITE);
            coef_addr  <= cur_addr_n;
            coef_data  <= coeff_n;
            busy       <= fill_next_s;
            status_out <= {13'd0, overrun_n, mismatch_n, fill_next_s, words_n};
        end
    end

endmodule

// File: tb/tb_quant_coeff_loader.sv
module tb_quant_coeff_loader;

    localparam int SETTLE = 2;
`ifdef QUANT_LOADER_READBACK_EN
    localparam int          P  = 3;
    localparam logic [31:0] MB = 32'h0002_0000;
`else
    localparam int          P  = 1;
    localparam logic [31:0] MB = 32'h0000_0000;
`endif

    logic        user_clk = 1'b0;
    logic        user_rst;
    logic [31:0] addr_reg_in;
    logic [31:0] data_reg_in;
    logic [9:0]  coef_addr;
    logic [31:0] coef_data;
    logic        coef_we;
    logic [31:0] coef_rd_data;
    logic        busy;
    logic [31:0] status_out;

    quant_coeff_loader #(.ADDR_W(10), .DATA_W(32), .SETTLE(SETTLE)) dut (
        .user_clk     (user_clk),
        .user_rst     (user_rst),
        .addr_reg_in  (addr_reg_in),
        .data_reg_in  (data_reg_in),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .coef_we      (coef_we),
        .coef_rd_data (coef_rd_data),
        .busy         (busy),
        .status_out   (status_out)
    );

    always #5 user_clk = ~user_clk;

    // RAM model; location 5 reads back with bit 0 flipped.
    logic [31:0] ram [0:1023];
    always @(posedge user_clk) begin
        if (coef_we) ram[coef_addr] <= coef_data;
        coef_rd_data <= (coef_addr == 10'd5) ? (ram[coef_addr] ^ 32'h1) : ram[coef_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    endtask

    // Reference model: transaction view of the loader driven by input history.
    int          edge_k = 0;
    int          chg    = 0;      // last edge where the address changed or reset
    logic [31:0] m_a_p  = 32'h0;  // address sampled at previous edge
    logic [31:0] m_d_p  = 32'h0;
    logic        m_init = 1'b0, m_busy = 1'b0, m_we = 1'b0;
    logic        m_ovr = 1'b0, m_mis = 1'b0, m_last = 1'b0, m_cap = 1'b0;
    int          m_ph = 0, m_left = 0;
    logic [9:0]  m_addr = 10'h0;
    logic [31:0] m_data = 32'h0;
    logic [15:0] m_words = 16'h0;

    task automatic model_step(input logic r, input logic [31:0] a, input logic [31:0] d);
        edge_k++;
        if (r) begin
            m_we = 1'b0; m_busy = 1'b0; m_addr = 10'h0; m_data = 32'h0;
            m_words = 16'h0; m_ovr = 1'b0; m_mis = 1'b0; m_init = 1'b1;
            chg = edge_k;
        end else begin
            if (m_we) m_words = m_words + 16'd1;
            if (m_busy) begin
                if (m_a_p[31] != m_cap) m_ovr = 1'b1;
                if (m_ph == P - 1) begin
                    if (P == 3 && m_addr == 10'd5) m_mis = 1'b1;
                    if (m_left == 0) begin
                        m_busy = 1'b0; m_we = 1'b0; m_last = m_a_p[31];
                    end else begin
                        m_left--; m_addr = m_addr + 10'd1; m_we = 1'b1; m_ph = 0;
                    end
                end else begin
                    m_ph++; m_we = 1'b0;
                end
            end else if (m_init) begin
                m_last = m_a_p[31]; m_init = 1'b0; m_we = 1'b0;
            end else if (m_a_p[31] != m_last && (edge_k - 1 - chg) >= SETTLE) begin
                m_busy = 1'b1; m_we = 1'b1; m_ph = 0;
                m_left = int'(m_a_p[25:16]); m_addr = m_a_p[9:0];
                m_data = m_d_p; m_cap = m_a_p[31]; m_last = m_a_p[31];
            end else begin
                m_we = 1'b0;
            end
            if (a != m_a_p) chg = edge_k;
        end
        m_a_p = a;
        m_d_p = d;
    endtask

    // One clock: drive, let the DUT and model take the edge, compare at negedge.
    task automatic tick(input logic r, input logic [31:0] a, input logic [31:0] d);
        user_rst    = r;
        addr_reg_in = a;
        data_reg_in = d;
        @(posedge user_clk);
        model_step(r, a, d);
        @(negedge user_clk);
        check("coef_we",   32'(coef_we),   32'(m_we));
        check("busy",      32'(busy),      32'(m_busy));
        check("coef_addr", 32'(coef_addr), 32'(m_addr));
        check("coef_data", coef_data,      m_data);
        check("status",    status_out,     {13'd0, m_ovr, m_mis, m_busy, m_words});
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] addr;
        logic [31:0] data;
        int          cycles;
        logic        chk;
        logic [31:0] exp_status;
    } vec_t;

    vec_t vt [17];

    initial begin
        int          lat, nwe, nb;
        logic [9:0]  waddr;
        logic [31:0] wdata, cur_a, cur_d, na;
        logic [9:0]  wq[$];

        vt[0]  = '{1'b1, 32'h8000_0000, 32'h0000_0000,  3, 1'b1, 32'h0};
        vt[1]  = '{1'b0, 32'h8000_0000, 32'h0000_0000, 12, 1'b1, 32'h0};
        vt[2]  = '{1'b1, 32'h0000_0000, 32'h0000_1234,  3, 1'b1, 32'h0};
        vt[3]  = '{1'b0, 32'h0000_0000, 32'h0000_1234,  5, 1'b1, 32'h0};
        vt[4]  = '{1'b0, 32'h8000_0005, 32'h0000_1234, 12, 1'b1, 32'h0000_0001 | MB};
        vt[5]  = '{1'b0, 32'h0003_03FE, 32'hA5A5_A5A5, 20, 1'b1, 32'h0000_0005 | MB};
        vt[6]  = '{1'b0, 32'h8003_0010, 32'h0000_1111,  5, 1'b0, 32'h0};
        vt[7]  = '{1'b0, 32'h0003_0010, 32'h0000_1111, 20, 1'b1, 32'h0004_0009 | MB};
        vt[8]  = '{1'b0, 32'h8000_0020, 32'h0000_0077,  1, 1'b0, 32'h0};
        vt[9]  = '{1'b0, 32'h8000_0021, 32'h0000_0078, 15, 1'b1, 32'h0004_000A | MB};
        vt[10] = '{1'b0, 32'h8400_0021, 32'h0000_0078, 10, 1'b1, 32'h0004_000A | MB};
        vt[11] = '{1'b0, 32'h8400_0021, 32'h0000_DEAD,  8, 1'b1, 32'h0004_000A | MB};
        vt[12] = '{1'b0, 32'h0001_03FF, 32'h0000_BEEF, 15, 1'b1, 32'h0004_000C | MB};
        vt[13] = '{1'b0, 32'h800F_0100, 32'h0000_0005,  6, 1'b0, 32'h0};
        vt[14] = '{1'b1, 32'h800F_0100, 32'h0000_0005,  2, 1'b1, 32'h0};
        vt[15] = '{1'b0, 32'h800F_0100, 32'h0000_0005, 20, 1'b1, 32'h0};
        vt[16] = '{1'b0, 32'h0000_0005, 32'h0000_0055, 12, 1'b1, 32'h0000_0001 | MB};

        for (int i = 0; i < 17; i++) begin
            for (int c = 0; c < vt[i].cycles; c++) tick(vt[i].rst, vt[i].addr, vt[i].data);
            if (vt[i].chk) check($sformatf("vec%0d status", i), status_out, vt[i].exp_status);
        end

        // First-write latency after a clean reset.
        for (int c = 0; c < 3; c++) tick(1'b1, 32'h0, 32'h0);
        for (int c = 0; c < 5; c++) tick(1'b0, 32'h0, 32'h0);
        lat = 0; nwe = 0; waddr = 10'h0; wdata = 32'h0;
        for (int c = 1; c <= 20; c++) begin
            tick(1'b0, 32'h8000_0005, 32'h0000_1234);
            if (coef_we && lat == 0) begin
                lat = c; waddr = coef_addr; wdata = coef_data;
            end
            if (coef_we) nwe++;
        end
        check("latency",      32'(lat),   32'(SETTLE + 2));
        check("lat addr",     32'(waddr), 32'h5);
        check("lat data",     wdata,      32'h0000_1234);
        check("lat writes",   32'(nwe),   32'h1);

        // Wrapping 4-word fill: busy duration and address sequence.
        nb = 0;
        for (int c = 0; c < 30; c++) begin
            tick(1'b0, 32'h0003_03FE, 32'hA5A5_A5A5);
            if (busy) nb++;
            if (coef_we) wq.push_back(coef_addr);
        end
        check("fill busy cycles", 32'(nb), 32'(4 * P));
        check("fill writes", 32'(wq.size()), 32'h4);
        for (int i = 0; i < wq.size() && i < 4; i++)
            check($sformatf("fill addr%0d", i), 32'(wq[i]), 32'((10'h3FE + 10'(i)) & 10'h3FF));

        // Randomized traffic against the model.
        cur_a = 32'h0003_03FE;
        cur_d = 32'hA5A5_A5A5;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                for (int c = 0; c < int'($urandom_range(1, 2)); c++) tick(1'b1, cur_a, cur_d);
            end else begin
                na = $urandom;
                na[25:16] = 10'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) na[9:0] = 10'h3FE;
                case ($urandom_range(0, 3))
                    0: na = cur_a ^ 32'h8000_0000;
                    1: na = cur_a ^ (32'h1 << $urandom_range(26, 30));
                    default: ;
                endcase
                cur_a = na;
                cur_d = $urandom;
                for (int c = 0; c < int'($urandom_range(1, 10)); c++) begin
                    if ($urandom_range(0, 7) == 0) cur_d = $urandom;
                    tick(1'b0, cur_a, cur_d);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
